text_overlay: RTL and testbench



---
 rtl/text_overlay_if.sv | 13 +
 rtl/text_overlay.sv | 99 +++++++++
 tb/tb_text_overlay.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/text_overlay_if.sv
// text_overlay_if: pixel stream, glyph-buffer write port and pixel-on result of the overlay
interface text_overlay_if;
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
    logic       frame_tick;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [4:0] wr_data;
    logic       overlay_active;
    modport master(output x, y, en, frame_tick, wr_en, wr_addr, wr_data, input overlay_active);
    modport slave(input x, y, en, frame_tick, wr_en, wr_addr, wr_data, output overlay_active);
endinterface

// File: rtl/text_overlay.sv
// text_overlay: scaled 5x7 hex-glyph text renderer with per-slot blink and 2-cycle pixel latency
module text_overlay #(
    parameter int CHARS        = 4,
    parameter int X0           = 30,
    parameter int Y0           = 24,
    parameter int SCALE_LOG2   = 3,
    parameter int BLINK_FRAMES = 30
) (
    input logic          clk,
    input logic          rst_n,
    text_overlay_if.slave bus
);
    // Row 7 is the blank spacing row, so no separate row<7 test is needed
    localparam logic [4:0] FONT [16][8] = '{
        '{5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E, 5'h00},
        '{5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E, 5'h00},
        '{5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F, 5'h00},
        '{5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E, 5'h00},
        '{5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02, 5'h00},
        '{5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E, 5'h00},
        '{5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E, 5'h00},
        '{5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08, 5'h00},
        '{5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E, 5'h00},
        '{5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C, 5'h00},
        '{5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11, 5'h00},
        '{5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E, 5'h00},
        '{5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E, 5'h00},
        '{5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C, 5'h00},
        '{5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F, 5'h00},
        '{5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10, 5'h00}
    };
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [4:0]    slots [16];
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic [9:0]    cx, cy;
    logic [10:0]   dxw, dyw;
    logic          in_region;
    logic [3:0]    k;
    logic [2:0]    col, row;
    logic          s1_hit, s1_phase;
    logic [2:0]    s1_col, s1_row;
    logic [4:0]    s1_slot;
    logic [5:0]    glyph;
    logic          active_q;

    assign bus.overlay_active = active_q;

    // Widened subtraction: a negative offset (left of/above the region) sets bit 10
    always_comb begin
        cx        = bus.x >> SCALE_LOG2;
        cy        = bus.y >> SCALE_LOG2;
        dxw       = 11'(cx) - 11'(X0);
        dyw       = 11'(cy) - 11'(Y0);
        in_region = bus.en && !dxw[10] && dxw[9:0] < 10'(6 * CHARS) && !dyw[10] && dyw[9:0] < 10'd8;
        k         = 4'(dxw[9:0] / 10'd6);
        col       = 3'(dxw[9:0] % 10'd6);
        row       = dyw[2:0];
        glyph     = {FONT[s1_slot[3:0]][s1_row], 1'b0};
    end

    // Slots at or above CHARS are never written and never read inside the region
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) slots[i] <= '0;
        end else if (bus.wr_en && 5'(bus.wr_addr) < 5'(CHARS)) begin
            slots[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (bus.frame_tick) begin
            frame_cnt   <= frame_cnt == FW'(BLINK_FRAMES - 1) ? '0 : frame_cnt + 1'b1;
            blink_phase <= blink_phase ^ (frame_cnt == FW'(BLINK_FRAMES - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hit   <= 1'b0;
            s1_phase <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
            s1_slot  <= '0;
            active_q <= 1'b0;
        end else begin
            s1_hit   <= in_region;
            s1_phase <= blink_phase;
            s1_col   <= col;
            s1_row   <= row;
            s1_slot  <= slots[k];
            active_q <= s1_hit && glyph[3'd5 - s1_col] && !(s1_slot[4] && s1_phase);
        end
    end
endmodule

// File: tb/tb_text_overlay.sv
// tb_text_overlay: directed plus random pixels on two configurations, checked against a glyph-table model
module tb_text_overlay;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    text_overlay_if ifa();
    text_overlay_if ifb();

    text_overlay #(.BLINK_FRAMES(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    text_overlay #(.X0(0), .Y0(0), .SCALE_LOG2(0), .BLINK_FRAMES(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    typedef struct {
        logic e;
        int   x;
        int   y;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   ncmp = 0;
    int   nfail = 0;
    int   code_m[4];
    int   blink_m[4];
    int   ticks;

    // Glyph rows top to bottom, leftmost column first
    string font_tb [16] = '{
        "01110 10001 10011 10101 11001 10001 01110",
        "00100 01100 00100 00100 00100 00100 01110",
        "01110 10001 00001 00010 00100 01000 11111",
        "11111 00010 00100 00010 00001 10001 01110",
        "00010 00110 01010 10010 11111 00010 00010",
        "11111 10000 11110 00001 00001 10001 01110",
        "00110 01000 10000 11110 10001 10001 01110",
        "11111 00001 00010 00100 01000 01000 01000",
        "01110 10001 10001 01110 10001 10001 01110",
        "01110 10001 10001 01111 00001 00010 01100",
        "01110 10001 10001 11111 10001 10001 10001",
        "11110 10001 10001 11110 10001 10001 11110",
        "01110 10001 10000 10000 10000 10001 01110",
        "11100 10010 10001 10001 10001 10010 11100",
        "11111 10000 10000 11110 10000 10000 11111",
        "11111 10000 10000 11110 10000 10000 10000"
    };

    function automatic logic model_px(int s, int x0, int y0, int bf, int x, int y, logic en);
        int cx = x >> s;
        int cy = y >> s;
        int k, col, row;
        if (!en || cx < x0 || cx >= x0 + 24 || cy < y0 || cy >= y0 + 8) return 1'b0;
        k   = (cx - x0) / 6;
        col = (cx - x0) % 6;
        row = cy - y0;
        if (col == 5 || row == 7) return 1'b0;
        if (blink_m[k] != 0 && (ticks / bf) % 2 == 1) return 1'b0;
        return font_tb[code_m[k]].getc(row * 6 + col) == "1";
    endfunction

    task automatic check(string tag, logic got, logic exp, int x, int y);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s x=%0d y=%0d got=%b want=%b", tag, x, y, got, exp);
        end
    endtask

    task automatic drive(int x, int y, logic en, logic tick, logic we, int wa, int wd);
        ifa.x = 10'(x);          ifb.x = 10'(x);
        ifa.y = 10'(y);          ifb.y = 10'(y);
        ifa.en = en;             ifb.en = en;
        ifa.frame_tick = tick;   ifb.frame_tick = tick;
        ifa.wr_en = we;          ifb.wr_en = we;
        ifa.wr_addr = 4'(wa);    ifb.wr_addr = 4'(wa);
        ifa.wr_data = 5'(wd);    ifb.wr_data = 5'(wd);
    endtask

    // One pixel per call; a negative want defers to the model
    task automatic cyc(int x, int y, logic en, logic tick, logic we, int wa, int wd, int want_a, int want_b);
        exp_t ea, eb;
        drive(x, y, en, tick, we, wa, wd);
        ea.e = want_a < 0 ? model_px(3, 30, 24, 2, x, y, en) : want_a[0];
        eb.e = want_b < 0 ? model_px(0, 0, 0, 3, x, y, en) : want_b[0];
        ea.x = x; ea.y = y; eb.x = x; eb.y = y;
        qa.push_back(ea);
        qb.push_back(eb);
        if (we && wa < 4) begin
            code_m[wa]  = wd & 15;
            blink_m[wa] = (wd >> 4) & 1;
        end
        if (tick) ticks++;
        @(posedge clk);
        #1;
        if (qa.size() >= 2) begin
            ea = qa.pop_front();
            check("a_px", ifa.overlay_active, ea.e, ea.x, ea.y);
        end
        if (qb.size() >= 2) begin
            eb = qb.pop_front();
            check("b_px", ifb.overlay_active, eb.e, eb.x, eb.y);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_a", ifa.overlay_active, 1'b0, -1, -1);
        check("rst_b", ifb.overlay_active, 1'b0, -1, -1);
        qa.delete();
        qb.delete();
        for (int i = 0; i < 4; i++) begin
            code_m[i]  = 0;
            blink_m[i] = 0;
        end
        ticks = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        drive(0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        // Empty buffer shows '0': row 1 col 0 lit
        cyc(240, 200, 1'b1, 1'b0, 1'b0, 0, 0, 1, -1);
        cyc(240, 200, 1'b1, 1'b0, 1'b0, 0, 0, 1, -1);
        // '8' in slot 0, then reset while the output is high
        cyc(0, 0, 1'b1, 1'b0, 1'b1, 0, 8, -1, -1);
        cyc(264, 208, 1'b1, 1'b0, 1'b0, 0, 0, 0, -1);
        repeat (3) cyc(248, 192, 1'b1, 1'b0, 1'b0, 0, 0, 1, -1);
        do_reset();
        cyc(264, 208, 1'b1, 1'b0, 1'b0, 0, 0, 1, -1);
        cyc(264, 208, 1'b1, 1'b0, 1'b0, 0, 0, 1, -1);
        // Basic glyph '8'
        cyc(0, 0, 1'b1, 1'b0, 1'b1, 0, 8, -1, -1);
        cyc(248, 192, 1'b1, 1'b0, 1'b0, 0, 0, 1, -1);
        cyc(240, 192, 1'b1, 1'b0, 1'b0, 0, 0, 0, -1);
        cyc(280, 192, 1'b1, 1'b0, 1'b0, 0, 0, 0, -1);
        // Region bounds
        cyc(424, 192, 1'b1, 1'b0, 1'b0, 0, 0, 0, -1);
        cyc(432, 192, 1'b1, 1'b0, 1'b0, 0, 0, 0, -1);
        cyc(232, 192, 1'b1, 1'b0, 1'b0, 0, 0, 0, -1);
        cyc(248, 256, 1'b1, 1'b0, 1'b0, 0, 0, 0, -1);
        // Blinking 'F' in slot 1
        cyc(0, 0, 1'b1, 1'b0, 1'b1, 1, 5'h1F, -1, -1);
        cyc(288, 192, 1'b1, 1'b0, 1'b0, 0, 0, 1, -1);
        cyc(248, 192, 1'b1, 1'b1, 1'b0, 0, 0, 1, -1);
        cyc(248, 192, 1'b1, 1'b1, 1'b0, 0, 0, 1, -1);
        cyc(288, 192, 1'b1, 1'b0, 1'b0, 0, 0, 0, -1);
        cyc(248, 192, 1'b1, 1'b1, 1'b0, 0, 0, 1, -1);
        cyc(248, 192, 1'b1, 1'b1, 1'b0, 0, 0, 1, -1);
        cyc(288, 192, 1'b1, 1'b0, 1'b0, 0, 0, 1, -1);
        // Write collision: same-cycle pixel sees old '8', next sees '1'
        cyc(248, 192, 1'b1, 1'b0, 1'b1, 0, 1, 1, -1);
        cyc(248, 192, 1'b1, 1'b0, 1'b0, 0, 0, 0, -1);
        // Out-of-range slot write ignored
        cyc(0, 0, 1'b1, 1'b0, 1'b1, 5, 8, -1, -1);
        cyc(248, 192, 1'b1, 1'b0, 1'b0, 0, 0, 0, -1);
        cyc(288, 192, 1'b1, 1'b0, 1'b0, 0, 0, 1, -1);
        // Unscaled configuration with '1' in slot 0
        cyc(2, 0, 1'b1, 1'b0, 1'b0, 0, 0, -1, 1);
        cyc(1, 0, 1'b1, 1'b0, 1'b0, 0, 0, -1, 0);
        for (int i = 0; i < 20; i++)
            cyc($urandom_range(0, 7), $urandom_range(0, 7), 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        // Random pixels, writes and ticks
        for (int i = 0; i < 3000; i++) begin
            int m = $urandom_range(0, 3);
            int x = m == 0 ? $urandom_range(224, 447) : m == 1 ? $urandom_range(0, 30) : $urandom_range(0, 1023);
            int y = m == 0 ? $urandom_range(184, 263) : m == 1 ? $urandom_range(0, 10) : $urandom_range(0, 1023);
            cyc(x, y, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7), $urandom_range(0, 31), -1, -1);
        end
        cyc(0, 0, 1'b0, 1'b0, 1'b0, 0, 0, -1, -1);
        cyc(0, 0, 1'b0, 1'b0, 1'b0, 0, 0, -1, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
